unidad_busqueda: RTL

UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

---
 rtl/paquete_rv32i.sv | 12 +
 rtl/unidad_busqueda_if.sv | 23 ++
 rtl/registro_pc.sv | 40 ++++
 rtl/unidad_busqueda.sv | 126 ++++++++++++
 4 files changed

// File: rtl/paquete_rv32i.sv
// Shared RV32I definitions for the fetch unit: FSM encoding, NOP encoding and opcode width.
package paquete_rv32i;

  typedef enum logic {
    REPOSO = 1'b0,
    ESPERA = 1'b1
  } estado_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          ANCHO_OP  = 7;

endpackage

// File: rtl/unidad_busqueda_if.sv
// Instruction memory request/response bus between the fetch unit (master) and memory (slave).
interface unidad_busqueda_if;

  logic        mem_req;
  logic [31:0] mem_dir;
  logic [31:0] mem_dato;
  logic        mem_listo;

  modport master (
    output mem_req,
    output mem_dir,
    input  mem_dato,
    input  mem_listo
  );

  modport slave (
    input  mem_req,
    input  mem_dir,
    output mem_dato,
    output mem_listo
  );

endinterface

// File: rtl/registro_pc.sv
// Program counter register: loads pc_sig on jump or taken branch, rejects misaligned targets.
module registro_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        esc_pc,
  input  logic        branch,
  input  logic        cero,
  input  logic [31:0] pc_sig,
  output logic [31:0] pc,
  output logic        error_alin
);

  logic [31:0] pc_reg;
  logic        error_alin_reg;
  logic        escribir;
  logic        alineado;

  assign escribir = esc_pc | (branch & cero);
  assign alineado = (pc_sig[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg         <= RESET_PC;
      error_alin_reg <= 1'b0;
    end else if (escribir) begin
      // A misaligned target leaves the PC untouched and latches the error until reset.
      if (alineado) begin
        pc_reg <= pc_sig;
      end else begin
        error_alin_reg <= 1'b1;
      end
    end
  end

  assign pc         = pc_reg;
  assign error_alin = error_alin_reg;

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction fetch unit: REPOSO/ESPERA handshake with instruction memory, IR and PC bookkeeping.
// Optional memory wait timeout enabled by defining UNIDAD_BUSQUEDA_TIMEOUT_EN.
module unidad_busqueda
  import paquete_rv32i::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          TIEMPO_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                esc_inst,
  input  logic                esc_pc,
  input  logic                branch,
  input  logic                cero,
  input  logic [31:0]         pc_sig,
  unidad_busqueda_if.master   mem,
  output logic [31:0]         instruccion,
  output logic [ANCHO_OP-1:0] op,
  output logic [31:0]         pc,
  output logic [31:0]         pc_ant,
  output logic                ocupado,
  output logic                error_alin,
  output logic                error_tiempo
);

  estado_t     state_reg, state_next;
  logic [31:0] mem_dir_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_ant_reg;
  logic        inicio;
  logic        cargar_ir;
  logic        vencido;

  registro_pc #(
    .RESET_PC(RESET_PC)
  ) u_registro_pc (
    .clk       (clk),
    .reset_n   (reset_n),
    .esc_pc    (esc_pc),
    .branch    (branch),
    .cero      (cero),
    .pc_sig    (pc_sig),
    .pc        (pc),
    .error_alin(error_alin)
  );

  always_comb begin
    state_next = state_reg;
    inicio     = 1'b0;
    cargar_ir  = 1'b0;
    case (state_reg)
      REPOSO: begin
        if (esc_inst) begin
          state_next = ESPERA;
          inicio     = 1'b1;
        end
      end
      ESPERA: begin
        if (mem.mem_listo) begin
          state_next = REPOSO;
          cargar_ir  = 1'b1;
        end else if (vencido) begin
          state_next = REPOSO;
        end
      end
      default: state_next = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= REPOSO;
      mem_dir_reg <= RESET_PC;
      instr_reg   <= INSTR_NOP;
      pc_ant_reg  <= RESET_PC;
    end else begin
      state_reg <= state_next;
      // The address is captured once per fetch so later PC writes cannot disturb it.
      if (inicio) begin
        mem_dir_reg <= pc;
      end
      if (cargar_ir) begin
        instr_reg  <= mem.mem_dato;
        pc_ant_reg <= mem_dir_reg;
      end
    end
  end

`ifdef UNIDAD_BUSQUEDA_TIMEOUT_EN
  localparam int ANCHO_CNT = (TIEMPO_MAX > 1) ? $clog2(TIEMPO_MAX) : 1;

  logic [ANCHO_CNT-1:0] cnt_reg;
  logic                 error_tiempo_reg;

  assign vencido = (state_reg == ESPERA) && (cnt_reg == ANCHO_CNT'(TIEMPO_MAX - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg          <= '0;
      error_tiempo_reg <= 1'b0;
    end else begin
      if (inicio) begin
        cnt_reg <= '0;
      end else if (state_reg == ESPERA) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (vencido && !mem.mem_listo) begin
        error_tiempo_reg <= 1'b1;
      end
    end
  end

  assign error_tiempo = error_tiempo_reg;
`else
  assign vencido      = 1'b0;
  assign error_tiempo = 1'b0;
`endif

  assign mem.mem_req = (state_reg == ESPERA);
  assign mem.mem_dir = mem_dir_reg;
  assign ocupado     = (state_reg == ESPERA);
  assign instruccion = instr_reg;
  assign op          = instr_reg[ANCHO_OP-1:0];
  assign pc_ant      = pc_ant_reg;

endmodule
